// File: rtl/clkdiv_multi_if.sv
// Control/status bundle of the multi-channel clock divider.
// The master side drives writes, enables, realign and readback select; the slave is the divider.
interface clkdiv_multi_if #(
  parameter int NCH = 2,
  parameter int W   = 28,
  parameter int CHW = 4
);
  // wr_en is a single-cycle strobe with no ready: the divider accepts every write on the
  // edge that samples it, so there is no backpressure and no valid/ready pairing.
  logic           wr_en;
  logic [CHW-1:0] wr_ch;
  logic [W-1:0]   wr_data;
  logic [NCH-1:0] en;
  logic           sync;
  logic           clr_err;
  logic [CHW-1:0] rd_ch;
  logic [W-1:0]   rd_half;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] rise_stb;
  logic           clamp_err;
  logic           addr_err;

  modport master (
    output wr_en, wr_ch, wr_data, en, sync, clr_err, rd_ch,
    input  rd_half, clk_out, rise_stb, clamp_err, addr_err
  );

  modport slave (
    input  wr_en, wr_ch, wr_data, en, sync, clr_err, rd_ch,
    output rd_half, clk_out, rise_stb, clamp_err, addr_err
  );
endinterface

// File: rtl/clkdiv_multi.sv
// N-channel programmable clock divider with per-channel enable, rising-edge strobe,
// glitch-free divisor update at reload, and a global phase-realign input.
module clkdiv_multi #(
  parameter int NCH          = 2,
  parameter int W            = 28,
  parameter int CHW          = 4,
  parameter int MIN_HALF     = 4,
  parameter int DEFAULT_HALF = 25000000
) (
  input logic           clkin,
  input logic           rst_n,
  clkdiv_multi_if.slave bus
);
  localparam logic [W-1:0] MIN_C = W'(MIN_HALF);
  localparam logic [W-1:0] DEF_C = W'(DEFAULT_HALF);
  localparam logic [W-1:0] ONE_C = W'(1);
  localparam logic [CHW:0] NCH_C = (CHW+1)'(NCH);

  logic [W-1:0]   pend [NCH];
  logic [W-1:0]   act  [NCH];
  logic [W-1:0]   cnt  [NCH];
  logic [NCH-1:0] clk_r;
  logic [NCH-1:0] stb_r;
  logic           clamp_r;
  logic           addr_r;
  logic           wr_ok;
  logic           wr_bad;
  logic           wr_small;
  logic [W-1:0]   wr_val;
  logic [W-1:0]   rd_val;

  assign wr_ok    = bus.wr_en && ({1'b0, bus.wr_ch} < NCH_C);
  assign wr_bad   = bus.wr_en && !({1'b0, bus.wr_ch} < NCH_C);
  assign wr_small = bus.wr_data < MIN_C;
  assign wr_val   = wr_small ? MIN_C : bus.wr_data;

  // Reload reads pend before this edge's write lands, so a write in a reload cycle
  // only takes effect at the following reload.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        pend[i] <= DEF_C;
        act[i]  <= DEF_C;
        cnt[i]  <= DEF_C - ONE_C;
      end
      clk_r <= '0;
      stb_r <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_ok && (bus.wr_ch == CHW'(i))) begin
          pend[i] <= wr_val;
        end
        if (bus.sync || !bus.en[i]) begin
          cnt[i]   <= pend[i] - ONE_C;
          act[i]   <= pend[i];
          clk_r[i] <= 1'b0;
          stb_r[i] <= 1'b0;
        end else if (cnt[i] == '0) begin
          cnt[i]   <= pend[i] - ONE_C;
          act[i]   <= pend[i];
          clk_r[i] <= !clk_r[i];
          stb_r[i] <= !clk_r[i];
        end else begin
          cnt[i]   <= cnt[i] - ONE_C;
          stb_r[i] <= 1'b0;
        end
      end
    end
  end

  // Sticky flags: a new error in the same cycle as clr_err wins.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      clamp_r <= 1'b0;
      addr_r  <= 1'b0;
    end else begin
      if (wr_ok && wr_small) begin
        clamp_r <= 1'b1;
      end else if (bus.clr_err) begin
        clamp_r <= 1'b0;
      end
      if (wr_bad) begin
        addr_r <= 1'b1;
      end else if (bus.clr_err) begin
        addr_r <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.rd_ch == CHW'(i)) begin
        rd_val = act[i];
      end
    end
  end

  assign bus.rd_half   = rd_val;
  assign bus.clk_out   = clk_r;
  assign bus.rise_stb  = stb_r;
  assign bus.clamp_err = clamp_r;
  assign bus.addr_err  = addr_r;
endmodule

// File: tb/tb_clkdiv_multi.sv
// Bench for clkdiv_multi: directed vector table, hand-written corner sequences, and a
// randomized phase checked every cycle against a toggle-time scheduling model.
module tb_clkdiv_multi;
  localparam int NCH      = 2;
  localparam int W        = 12;
  localparam int CHW      = 4;
  localparam int MIN_HALF = 4;
  localparam int DEF_HALF = 8;

  if (DEF_HALF < MIN_HALF) begin : g_cfg_bad
    initial begin
      $display("FAIL cfg: DEFAULT_HALF=%0d below MIN_HALF=%0d", DEF_HALF, MIN_HALF);
      $fatal(1);
    end
  end

  logic clkin;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;
  logic mon_on  = 1'b0;

  clkdiv_multi_if #(.NCH(NCH), .W(W), .CHW(CHW)) bus ();

  clkdiv_multi #(
    .NCH(NCH), .W(W), .CHW(CHW), .MIN_HALF(MIN_HALF), .DEFAULT_HALF(DEF_HALF)
  ) dut (
    .clkin(clkin),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference model: each channel keeps the absolute edge number of its next toggle.
  int             cyc = 0;
  int             m_pend [NCH];
  int             m_act  [NCH];
  int             m_nxt  [NCH];
  int             np;
  logic [NCH-1:0] m_clk;
  logic [NCH-1:0] m_stb;
  logic           m_clamp;
  logic           m_addr;

  always @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_pend[i] = DEF_HALF;
        m_act[i]  = DEF_HALF;
        m_nxt[i]  = cyc + DEF_HALF;
      end
      m_clk   = '0;
      m_stb   = '0;
      m_clamp = 1'b0;
      m_addr  = 1'b0;
    end else begin
      cyc++;
      for (int i = 0; i < NCH; i++) begin
        np = m_pend[i];
        if (bus.wr_en && int'(bus.wr_ch) == i) begin
          np = (int'(bus.wr_data) < MIN_HALF) ? MIN_HALF : int'(bus.wr_data);
        end
        m_stb[i] = 1'b0;
        if (bus.sync || !bus.en[i]) begin
          m_clk[i] = 1'b0;
          m_act[i] = m_pend[i];
          m_nxt[i] = cyc + m_pend[i];
        end else if (cyc == m_nxt[i]) begin
          m_clk[i] = !m_clk[i];
          m_stb[i] = m_clk[i];
          m_act[i] = m_pend[i];
          m_nxt[i] = cyc + m_pend[i];
        end
        m_pend[i] = np;
      end
      if (bus.wr_en && int'(bus.wr_ch) < NCH && int'(bus.wr_data) < MIN_HALF) m_clamp = 1'b1;
      else if (bus.clr_err) m_clamp = 1'b0;
      if (bus.wr_en && int'(bus.wr_ch) >= NCH) m_addr = 1'b1;
      else if (bus.clr_err) m_addr = 1'b0;
    end
  end

  logic [W-1:0] m_rd;
  always @(negedge clkin) begin
    if (mon_on) begin
      m_rd = '0;
      if (int'(bus.rd_ch) < NCH) m_rd = W'(m_act[bus.rd_ch]);
      chk($sformatf("model cyc%0d clk/stb/clamp/addr/rd", cyc),
          32'({bus.clk_out, bus.rise_stb, bus.clamp_err, bus.addr_err, bus.rd_half}),
          32'({m_clk, m_stb, m_clamp, m_addr, m_rd}));
    end
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic chk_out(input string name, input logic [1:0] e_clk, input logic [1:0] e_stb,
                         input logic [W-1:0] e_rd);
    chk({name, " clk_out"},  32'(bus.clk_out),  32'(e_clk));
    chk({name, " rise_stb"}, 32'(bus.rise_stb), 32'(e_stb));
    chk({name, " rd_half"},  32'(bus.rd_half),  32'(e_rd));
  endtask

  typedef struct {
    logic           wr_en;
    logic [CHW-1:0] wr_ch;
    logic [W-1:0]   wr_data;
    logic [NCH-1:0] en;
    logic           sync;
    logic           clr;
    logic [CHW-1:0] rd_ch;
    int             n;
    logic [NCH-1:0] e_clk;
    logic [NCH-1:0] e_stb;
    logic [W-1:0]   e_rd;
    logic           e_clamp;
    logic           e_addr;
  } vec_t;

  function automatic vec_t mk(logic we, int ch, int d, logic [1:0] e, logic s, logic c, int rc,
                              int n, logic [1:0] ec, logic [1:0] es, int er, logic ecl, logic ead);
    vec_t v;
    v.wr_en = we; v.wr_ch = CHW'(ch); v.wr_data = W'(d); v.en = e; v.sync = s; v.clr = c;
    v.rd_ch = CHW'(rc); v.n = n; v.e_clk = ec; v.e_stb = es; v.e_rd = W'(er);
    v.e_clamp = ecl; v.e_addr = ead;
    return v;
  endfunction

  vec_t vt [15];

  initial begin
    // Edge numbers in the comments count rising edges since reset release.
    vt[0]  = mk(0, 0, 0, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00, 8, 0, 0); // reset state
    vt[1]  = mk(0, 0, 0, 2'b11, 0, 0, 0, 7, 2'b00, 2'b00, 8, 0, 0); // edge 7
    vt[2]  = mk(0, 0, 0, 2'b11, 0, 0, 1, 1, 2'b11, 2'b11, 8, 0, 0); // edge 8: both rise
    vt[3]  = mk(0, 0, 0, 2'b11, 0, 0, 0, 1, 2'b11, 2'b00, 8, 0, 0); // edge 9
    vt[4]  = mk(1, 1, 5, 2'b11, 0, 0, 1, 1, 2'b11, 2'b00, 8, 0, 0); // edge 10: ch1 <- 5
    vt[5]  = mk(0, 0, 0, 2'b11, 0, 0, 1, 5, 2'b11, 2'b00, 8, 0, 0); // edge 15
    vt[6]  = mk(0, 0, 0, 2'b11, 0, 0, 1, 1, 2'b00, 2'b00, 5, 0, 0); // edge 16: reload to 5
    vt[7]  = mk(0, 0, 0, 2'b11, 0, 0, 1, 5, 2'b10, 2'b10, 5, 0, 0); // edge 21: ch1 rises
    vt[8]  = mk(0, 0, 0, 2'b11, 0, 0, 0, 3, 2'b11, 2'b01, 8, 0, 0); // edge 24: ch0 rises
    vt[9]  = mk(1, 0, 2, 2'b11, 0, 0, 0, 1, 2'b11, 2'b00, 8, 1, 0); // clamp
    vt[10] = mk(0, 0, 0, 2'b11, 0, 1, 0, 1, 2'b01, 2'b00, 8, 0, 0); // clear
    vt[11] = mk(1, 3, 9, 2'b11, 0, 0, 3, 1, 2'b01, 2'b00, 0, 0, 1); // bad address
    vt[12] = mk(0, 0, 0, 2'b11, 0, 1, 1, 1, 2'b01, 2'b00, 5, 0, 0); // clear
    vt[13] = mk(1, 0, 1, 2'b11, 0, 1, 0, 1, 2'b01, 2'b00, 8, 1, 0); // set wins over clear
    vt[14] = mk(0, 0, 0, 2'b11, 0, 1, 0, 1, 2'b01, 2'b00, 8, 0, 0); // edge 30

    rst_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_data = '0; bus.en = 2'b11;
    bus.sync = 1'b0; bus.clr_err = 1'b0; bus.rd_ch = '0;
    tick(3);
    rst_n  = 1'b1;
    mon_on = 1'b1;

    for (int r = 0; r < 15; r++) begin
      bus.wr_en = vt[r].wr_en; bus.wr_ch = vt[r].wr_ch; bus.wr_data = vt[r].wr_data;
      bus.en = vt[r].en; bus.sync = vt[r].sync; bus.clr_err = vt[r].clr; bus.rd_ch = vt[r].rd_ch;
      if (vt[r].n > 0) begin
        tick(1);
        bus.wr_en = 1'b0; bus.sync = 1'b0; bus.clr_err = 1'b0;
        tick(vt[r].n - 1);
      end else begin
        #1;
      end
      chk_out($sformatf("vec%0d", r), vt[r].e_clk, vt[r].e_stb, vt[r].e_rd);
      chk($sformatf("vec%0d clamp_err", r), 32'(bus.clamp_err), 32'(vt[r].e_clamp));
      chk($sformatf("vec%0d addr_err", r),  32'(bus.addr_err),  32'(vt[r].e_addr));
    end

    // Realign: ch0 half 4, ch1 half 12.
    bus.wr_en = 1'b1; bus.wr_ch = 4'd1; bus.wr_data = 12'd12;
    tick(1);
    bus.wr_en = 1'b0;
    tick(3);
    bus.sync = 1'b1; bus.rd_ch = 4'd1;
    tick(1);
    bus.sync = 1'b0;
    chk_out("sync s", 2'b00, 2'b00, 12);
    bus.rd_ch = 4'd0;
    tick(3);  chk_out("sync s+3",  2'b00, 2'b00, 4);
    tick(1);  chk_out("sync s+4",  2'b01, 2'b01, 4);
    tick(4);  chk_out("sync s+8",  2'b00, 2'b00, 4);
    tick(4);  chk_out("sync s+12", 2'b11, 2'b11, 4);

    // Disable ch0 mid-high for three edges, then re-enable.
    bus.en = 2'b10;
    tick(1);  chk_out("dis s+13", 2'b10, 2'b00, 4);
    tick(2);  chk_out("dis s+15", 2'b10, 2'b00, 4);
    bus.en = 2'b11;
    tick(3);  chk_out("ren s+18", 2'b10, 2'b00, 4);
    tick(1);  chk_out("ren s+19", 2'b11, 2'b01, 4);
    tick(1);  chk_out("ren s+20", 2'b11, 2'b00, 4);

    // Write lands on ch0's reload edge s+23.
    tick(2);
    bus.wr_en = 1'b1; bus.wr_ch = 4'd0; bus.wr_data = 12'd6;
    tick(1);
    bus.wr_en = 1'b0;
    chk_out("rld s+23", 2'b10, 2'b00, 4);
    tick(4);  chk_out("rld s+27", 2'b01, 2'b01, 6);
    tick(5);  chk_out("rld s+32", 2'b01, 2'b00, 6);
    tick(1);  chk_out("rld s+33", 2'b00, 2'b00, 6);

    // Asynchronous reset mid-run discards a pending write.
    bus.wr_en = 1'b1; bus.wr_ch = 4'd1; bus.wr_data = 12'd10; bus.rd_ch = 4'd1;
    tick(1);
    bus.wr_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_out("async rst", 2'b00, 2'b00, 8);
    tick(1);
    rst_n = 1'b1;
    tick(7);  chk_out("rst +7",  2'b00, 2'b00, 8);
    tick(1);  chk_out("rst +8",  2'b11, 2'b11, 8);
    tick(8);  chk_out("rst +16", 2'b00, 2'b00, 8);

    // Randomized phase, checked by the model every cycle.
    for (int k = 0; k < 800; k++) begin
      bus.wr_en   = ($urandom_range(0, 5) == 0);
      bus.wr_ch   = CHW'($urandom_range(0, 3));
      bus.wr_data = W'($urandom_range(0, 14));
      bus.sync    = ($urandom_range(0, 40) == 0);
      bus.clr_err = ($urandom_range(0, 12) == 0);
      bus.rd_ch   = CHW'($urandom_range(0, 3));
      if ($urandom_range(0, 25) == 0) bus.en = 2'($urandom_range(0, 3));
      if (k == 400) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick(1);
    end
    bus.wr_en = 1'b0; bus.sync = 1'b0; bus.clr_err = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
- Parametrised N-channel programmable clock divider and tick generator running from the 50 MHz system clock.
- Successor to the fixed two-output divider (control clock and data clock).
- Each channel has:
  - a runtime-programmable half-period;
  - glitch-free divisor update at the next reload;
  - enable gating;
  - a one-cycle rising-edge strobe;
  - a global phase-realign input so DAC control and data clocks can be started phase-locked.

Parameters:
- NCH, 2, number of divider channels (1..16).
- W, 28, half-period counter/divisor width.
- CHW, 4, channel-select width; requires 2**CHW >= NCH.
- MIN_HALF, 4, minimum legal half-period in cycles (4 = 6.25 MHz at 50 MHz, DAC bandwidth limit).
- DEFAULT_HALF, 25000000, half-period loaded into every channel at reset.

Ports:
- clkin  in  1  system clock (50 MHz), all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  divisor write strobe.
- wr_ch  in  CHW  channel addressed by the write.
- wr_data  in  W  requested half-period in cycles.
- en  in  NCH  per-channel run enable.
- sync  in  1  one-cycle realign pulse, applied to all channels.
- clr_err  in  1  clears the sticky error flags.
- rd_ch  in  CHW  readback channel select.
- rd_half  out  W  active half-period of rd_ch; combinational; 0 if rd_ch >= NCH.
- clk_out  out  NCH  divided clock outputs (registered).
- rise_stb  out  NCH  one-cycle pulse in the first cycle clk_out[i] is 1 (registered).
- clamp_err  out  1  sticky: a write below MIN_HALF was clamped.
- addr_err  out  1  sticky: a write addressed wr_ch >= NCH.

Behaviour:
- Per-channel state: pend[i] (W), act[i] (W), cnt[i] (W), clk_out[i], rise_stb[i].
- Reset (async, rst_n=0):
  - pend = act = DEFAULT_HALF; cnt = DEFAULT_HALF-1;
  - clk_out = 0; rise_stb = 0; clamp_err = addr_err = 0.
- Write (wr_en=1, wr_ch<NCH):
  - pend[wr_ch] <= max(wr_data, MIN_HALF) at that edge.
  - If wr_data < MIN_HALF, clamp_err <= 1.
  - act and cnt are not touched by the write.
- Write with wr_ch >= NCH: no state change except addr_err <= 1.
- Run (en[i]=1, no sync), per edge:
  - if cnt[i]==0: cnt[i] <= pend[i]-1; act[i] <= pend[i]; clk_out[i] toggles.
  - else cnt[i] <= cnt[i]-1.
  - Result: clk_out period = 2*act cycles, 50% duty. First toggle occurs act cycles after the counter is loaded.
- Divisor change is glitch-free:
  - a new pend takes effect only at a reload; the current half-period always completes.
  - A write landing in the same cycle as a reload is not bypassed: the reload uses the old pend, and the new value applies at the following reload.
- Disable (en[i]=0):
  - clk_out[i] <= 0; rise_stb[i] <= 0; cnt[i] <= pend[i]-1; act[i] <= pend[i].
  - Re-enable therefore starts a fresh low half-period of full length.
- rise_stb[i] <= 1 only on the edge where clk_out[i] goes 0->1; otherwise 0. It is never high for two consecutive cycles.
- sync=1 (priority over run, applies to every channel regardless of en):
  - cnt <= pend-1; act <= pend; clk_out <= 0; rise_stb <= 0.
  - All enabled channels then rise together when their half-periods share a common multiple.
- Priority per channel: reset > sync > en=0 > run.
- Error flags:
  - clr_err=1 clears both flags.
  - If clr_err and a new error occur in the same cycle, the flag sets (set wins).
- Counters never underflow; cnt is always in the range 0..act-1.
- Arithmetic: W-bit unsigned, no wrap.
- DEFAULT_HALF >= MIN_HALF is required; the bench checks this at elaboration.
- Reset mid-period: outputs drop to 0 immediately (asynchronous); pending writes are lost.

Test Plan:
- Reset release with DEFAULT_HALF=8, en=2'b11 -> both clk_out rise on the 8th edge with rise_stb high that cycle. Period is 16 cycles. rd_half reads 8.
- Write ch1=5 mid-period -> current ch1 half completes at 8 cycles, then half-periods are 5 (period 10). Ch0 is unaffected. rd_half(1) switches to 5 at the reload edge.
- Write ch0=2 -> pend=4 (MIN_HALF) and clamp_err=1. Assert clr_err -> clamp_err=0. Write wr_ch=3 (NCH=2) -> addr_err=1 and no channel changes.
- Ch0 half=4, ch1 half=12, running out of phase; pulse sync -> both clk_out=0 next cycle. Ch0 rises 4 cycles later; ch0 and ch1 rise together 12 cycles after sync.
- Drop en[0] for 3 cycles mid-high -> clk_out[0]=0 next edge. On re-enable, clk_out[0] rises after exactly act cycles and rise_stb pulses once.
- Write issued in the exact reload cycle -> old value used for that half-period, new value for the next. Assert rst_n low mid-run -> outputs 0 asynchronously and act returns to DEFAULT_HALF.
